vend_coin_feeder: RTL and testbench

- Coin-side transmitter for the vending FSM. It drives the 2-bit coin bus (01 = 5, 10 = 10, 00 = no coin) from a loaded payment plan.
- It monitors the machine's registered dispense/chg5 responses and reports items vended and change returned.
- It sits between the testbench or host controller and the vending FSM, replacing hand-written coin stimulus.

---
 rtl/vend_coin_feeder_if.sv | 30 +++
 rtl/vend_coin_feeder.sv | 164 ++++++++++++++++
 tb/tb_vend_coin_feeder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vend_coin_feeder_if.sv
// Coin-feeder bus: plan load, abort, vending responses
// and the coin bus / monitor results.
interface vend_coin_feeder_if #(
  parameter int CW = 4
);
  logic          start;
  logic [CW-1:0] n_five;
  logic [CW-1:0] n_ten;
  logic          five_first;
  logic          abort;
  logic          dispense;
  logic          chg5;
  logic [1:0]    coin;
  logic          busy;
  logic          done;
  logic [CW:0]   items;
  logic [CW:0]   changes;

  modport master (
    output start, n_five, n_ten, five_first, abort,
    output dispense, chg5,
    input  coin, busy, done, items, changes
  );

  modport slave (
    input  start, n_five, n_ten, five_first, abort,
    input  dispense, chg5,
    output coin, busy, done, items, changes
  );
endinterface

// File: rtl/vend_coin_feeder.sv
// Coin-side transmitter for the vending FSM: plays a
// payment plan onto the coin bus and counts responses.
module vend_coin_feeder #(
  parameter int CW  = 4,
  parameter int GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  vend_coin_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_GAP_LAST = 4'(GAP - 1);

  state_t        r_state;
  logic [CW-1:0] r_five;
  logic [CW-1:0] r_ten;
  logic          r_ff;
  logic [1:0]    r_coin;
  logic [3:0]    r_gap;
  logic [CW:0]   r_items;
  logic [CW:0]   r_changes;

  state_t        w_nxt;
  logic [CW-1:0] w_five_nxt;
  logic [CW-1:0] w_ten_nxt;
  logic          w_ff_nxt;
  logic [1:0]    w_coin_nxt;
  logic [3:0]    w_gap_nxt;
  logic [CW:0]   w_items_nxt;
  logic [CW:0]   w_changes_nxt;
  logic [CW-1:0] w_src_five;
  logic [CW-1:0] w_src_ten;
  logic          w_src_ff;
  logic          w_use_five;
  logic          w_busy;

  assign w_busy = (r_state == S_COIN) ||
                  (r_state == S_GAP)  ||
                  (r_state == S_DRAIN);

  // Coin choice reads the live inputs when a plan is being
  // loaded and the latched counters otherwise.
  always_comb begin
    w_src_five = r_five;
    w_src_ten  = r_ten;
    w_src_ff   = r_ff;
    if (r_state == S_IDLE) begin
      w_src_five = bus.n_five;
      w_src_ten  = bus.n_ten;
      w_src_ff   = bus.five_first;
    end
    w_use_five = w_src_ff ? (w_src_five != '0)
                          : (w_src_ten == '0);
  end

  // Next-state, next-coin and response monitor.
  always_comb begin
    w_nxt         = r_state;
    w_five_nxt    = r_five;
    w_ten_nxt     = r_ten;
    w_ff_nxt      = r_ff;
    w_coin_nxt    = 2'b00;
    w_gap_nxt     = r_gap;
    w_items_nxt   = r_items;
    w_changes_nxt = r_changes;

    if (w_busy && bus.dispense && !(&r_items))
      w_items_nxt = r_items + 1'b1;
    if (w_busy && bus.chg5 && !(&r_changes))
      w_changes_nxt = r_changes + 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_five_nxt    = bus.n_five;
          w_ten_nxt     = bus.n_ten;
          w_ff_nxt      = bus.five_first;
          w_items_nxt   = '0;
          w_changes_nxt = '0;
          if (bus.n_five == '0 && bus.n_ten == '0) begin
            w_nxt = S_DONE;
          end else begin
            w_nxt = S_COIN;
            if (w_use_five) begin
              w_coin_nxt = 2'b01;
              w_five_nxt = w_src_five - CW'(1);
            end else begin
              w_coin_nxt = 2'b10;
              w_ten_nxt  = w_src_ten - CW'(1);
            end
          end
        end
      end
      S_COIN: begin
        if (r_five != '0 || r_ten != '0) begin
          w_nxt     = S_GAP;
          w_gap_nxt = '0;
        end else begin
          w_nxt = S_DRAIN;
        end
      end
      S_GAP: begin
        if (r_gap == LP_GAP_LAST) begin
          w_nxt = S_COIN;
          if (w_use_five) begin
            w_coin_nxt = 2'b01;
            w_five_nxt = w_src_five - CW'(1);
          end else begin
            w_coin_nxt = 2'b10;
            w_ten_nxt  = w_src_ten - CW'(1);
          end
        end else begin
          w_gap_nxt = r_gap + 4'd1;
        end
      end
      S_DRAIN: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase

    if (w_busy && bus.abort) begin
      w_nxt      = S_IDLE;
      w_coin_nxt = 2'b00;
    end
  end

  // State, plan counters, coin bus and monitor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_five    <= '0;
      r_ten     <= '0;
      r_ff      <= 1'b0;
      r_coin    <= 2'b00;
      r_gap     <= '0;
      r_items   <= '0;
      r_changes <= '0;
    end else begin
      r_state   <= w_nxt;
      r_five    <= w_five_nxt;
      r_ten     <= w_ten_nxt;
      r_ff      <= w_ff_nxt;
      r_coin    <= w_coin_nxt;
      r_gap     <= w_gap_nxt;
      r_items   <= w_items_nxt;
      r_changes <= w_changes_nxt;
    end
  end

  assign bus.coin    = r_coin;
  assign bus.busy    = w_busy;
  assign bus.done    = (r_state == S_DONE);
  assign bus.items   = r_items;
  assign bus.changes = r_changes;

endmodule

// File: tb/tb_vend_coin_feeder.sv
// Directed bench for vend_coin_feeder with a small
// vending-machine responder model.
module tb_vend_coin_feeder;

  localparam int CW  = 4;
  localparam int GAP = 1;

  logic clk;
  logic reset;

  int n_assert;
  int n_fail;

  vend_coin_feeder_if #(.CW(CW)) u_if ();

  vend_coin_feeder #(
    .CW  (CW),
    .GAP (GAP)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       m_clr;
  logic       m_force;
  logic [5:0] m_credit;
  logic [5:0] m_sum;
  logic       m_disp;
  logic       m_chg;

  always_comb begin
    m_sum = m_credit;
    if (u_if.coin == 2'b01) m_sum = m_credit + 6'd5;
    if (u_if.coin == 2'b10) m_sum = m_credit + 6'd10;
  end

  // Vending responder: credit 20 vends, 25 vends plus change.
  always @(posedge clk) begin
    if (reset || m_clr) begin
      m_credit <= '0;
      m_disp   <= 1'b0;
      m_chg    <= 1'b0;
    end else if (m_sum >= 6'd20) begin
      m_credit <= '0;
      m_disp   <= 1'b1;
      m_chg    <= (m_sum == 6'd25);
    end else begin
      m_credit <= m_sum;
      m_disp   <= 1'b0;
      m_chg    <= 1'b0;
    end
  end

  assign u_if.dispense = m_disp | m_force;
  assign u_if.chg5     = m_chg  | m_force;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic plan(input int nf, input int nt,
                      input bit ff, input int ei,
                      input int ec);
    int total;
    logic [1:0] exp;
    total = nf + nt;
    @(negedge clk);
    u_if.n_five     = CW'(nf);
    u_if.n_ten      = CW'(nt);
    u_if.five_first = ff;
    u_if.start      = 1'b1;
    m_clr           = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    m_clr      = 1'b0;
    for (int k = 0; k < total; k++) begin
      if (ff) exp = (k < nf)  ? 2'b01 : 2'b10;
      else    exp = (k >= nt) ? 2'b01 : 2'b10;
      chk("coin", 32'(u_if.coin), 32'(exp));
      chk("busy", 32'(u_if.busy), 1);
      if (k < total - 1) begin
        for (int g = 0; g < GAP; g++) begin
          @(negedge clk);
          chk("gap_coin", 32'(u_if.coin), 0);
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    chk("drain_coin", 32'(u_if.coin), 0);
    chk("drain_done", 32'(u_if.done), 0);
    @(negedge clk);
    chk("done", 32'(u_if.done), 1);
    chk("done_busy", 32'(u_if.busy), 0);
    chk("items", 32'(u_if.items), 32'(ei));
    chk("changes", 32'(u_if.changes), 32'(ec));
    @(negedge clk);
    chk("done_pulse", 32'(u_if.done), 0);
  endtask

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    m_clr           = 1'b0;
    m_force         = 1'b0;
    u_if.start      = 1'b0;
    u_if.n_five     = '0;
    u_if.n_ten      = '0;
    u_if.five_first = 1'b0;
    u_if.abort      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coin", 32'(u_if.coin), 0);
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_done", 32'(u_if.done), 0);
    chk("rst_items", 32'(u_if.items), 0);
    chk("rst_changes", 32'(u_if.changes), 0);
    reset = 1'b0;
    @(negedge clk);

    plan(0, 2, 1'b0, 1, 0);

    u_if.n_five = '0;
    u_if.n_ten  = '0;
    u_if.start  = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("empty_done", 32'(u_if.done), 1);
    chk("empty_busy", 32'(u_if.busy), 0);
    chk("empty_coin", 32'(u_if.coin), 0);
    chk("empty_items", 32'(u_if.items), 0);
    @(negedge clk);
    chk("empty_pulse", 32'(u_if.done), 0);

    plan(3, 1, 1'b1, 1, 1);
    plan(4, 1, 1'b0, 1, 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("idle_rst_items", 32'(u_if.items), 0);

    u_if.n_five     = 4'd5;
    u_if.n_ten      = 4'd0;
    u_if.five_first = 1'b1;
    u_if.start      = 1'b1;
    m_clr           = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
    chk("ab_c1", 32'(u_if.coin), 1);
    u_if.n_five     = 4'd0;
    u_if.n_ten      = 4'd3;
    u_if.five_first = 1'b0;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("ab_g1", 32'(u_if.coin), 0);
    @(negedge clk);
    chk("ab_ign_start", 32'(u_if.coin), 1);
    @(negedge clk);
    chk("ab_g2_busy", 32'(u_if.busy), 1);
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    chk("ab_busy", 32'(u_if.busy), 0);
    chk("ab_coin", 32'(u_if.coin), 0);
    chk("ab_done", 32'(u_if.done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_quiet", 32'({u_if.coin, u_if.done}), 0);
    end

    u_if.n_five = 4'd0;
    u_if.n_ten  = 4'd1;
    u_if.start  = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("ab2_coin", 32'(u_if.coin), 2);
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    chk("ab2_busy", 32'(u_if.busy), 0);
    @(negedge clk);
    chk("ab2_done", 32'(u_if.done), 0);

    u_if.start = 1'b1;
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.abort = 1'b0;
    chk("sa_coin", 32'(u_if.coin), 2);
    chk("sa_busy", 32'(u_if.busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("sa_done", 32'(u_if.done), 1);

    @(negedge clk);
    u_if.n_five     = 4'd2;
    u_if.n_ten      = 4'd0;
    u_if.five_first = 1'b1;
    u_if.start      = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    chk("rs_c1", 32'(u_if.coin), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rs_coin", 32'(u_if.coin), 0);
    chk("rs_busy", 32'(u_if.busy), 0);
    chk("rs_items", 32'(u_if.items), 0);
    chk("rs_changes", 32'(u_if.changes), 0);
    plan(0, 1, 1'b0, 0, 0);

    m_force = 1'b1;
    plan(15, 15, 1'b1, 31, 31);
    m_force = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
